// File: rtl/alu_pkg.sv
// Shared ALU definitions: function codes used by the ALU control decoder and the
// execute unit, plus the execute-unit FSM and serial-shift mode encodings.
package alu_pkg;

    localparam logic [3:0] ALU_SLL = 4'b0000;
    localparam logic [3:0] ALU_SRL = 4'b0001;
    localparam logic [3:0] ALU_SRA = 4'b0010;
    localparam logic [3:0] ALU_ADD = 4'b1000;
    localparam logic [3:0] ALU_SUB = 4'b1001;
    localparam logic [3:0] ALU_AND = 4'b1100;
    localparam logic [3:0] ALU_OR  = 4'b1101;
    localparam logic [3:0] ALU_NOR = 4'b1110;
    localparam logic [3:0] ALU_XOR = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    // Low two bits of the shift function codes double as the shift mode.
    typedef enum logic [1:0] {
        SH_SLL = 2'b00,
        SH_SRL = 2'b01,
        SH_SRA = 2'b10
    } shift_mode_t;

    function automatic logic is_shift(input logic [3:0] func);
        return (func[3:2] == 2'b00) && (func[1:0] != 2'b11);
    endfunction

endpackage

// File: rtl/alu_serial_shifter.sv
// Bit-serial shifter: moves the loaded value one position per cycle until the
// down-counter expires; value is the one-step-ahead result, valid with done.
module alu_serial_shifter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    localparam int CW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  shift_mode_t      mode_in,
    input  logic [WIDTH-1:0] value_in,
    input  logic [CW-1:0]    count_in,
    output logic             done,
    output logic [WIDTH-1:0] value
);

    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] step;
    logic [CW-1:0]    count;
    shift_mode_t      mode;

    always_comb begin
        step = shift_reg;
        case (mode)
            SH_SLL:  step = {shift_reg[WIDTH-2:0], 1'b0};
            SH_SRL:  step = {1'b0, shift_reg[WIDTH-1:1]};
            SH_SRA:  step = {shift_reg[WIDTH-1], shift_reg[WIDTH-1:1]};
            default: step = shift_reg;
        endcase
    end

    // Last shift happens on the edge where the counter goes from 1 to 0.
    assign done  = (count == CW'(1));
    assign value = step;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shift_reg <= '0;
            count     <= '0;
            mode      <= SH_SLL;
        end else if (load) begin
            shift_reg <= value_in;
            count     <= count_in;
            mode      <= mode_in;
        end else if (count != '0) begin
            shift_reg <= step;
            count     <= count - CW'(1);
        end
    end

endmodule

// File: rtl/alu_seq_unit.sv
// Multi-cycle execute unit: logic and add/sub finish in one cycle, shifts run
// bit-serially in alu_serial_shifter; valid/ready handshake on both sides.
module alu_seq_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [3:0]       i_alu_func,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [SHW-1:0]   i_shamt,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_result,
    output logic             o_zero,
    output logic             o_overflow,
    output logic             o_illegal
);

    state_t           state;
    state_t           state_next;
    logic             accept;
    logic             start_shift;
    logic             shifter_done;
    logic             shift_done;
    logic [WIDTH-1:0] shift_value;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] alu_result;
    logic             alu_overflow;
    logic             alu_illegal;

    assign o_ready     = (state == ST_IDLE);
    assign o_valid     = (state == ST_DONE);
    assign accept      = i_valid && o_ready;
    assign start_shift = accept && is_shift(i_alu_func) && (i_shamt != '0);
    assign shift_done  = shifter_done && (state == ST_SHIFT);

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (accept)     state_next = start_shift ? ST_SHIFT : ST_DONE;
            ST_SHIFT: if (shift_done) state_next = ST_DONE;
            ST_DONE:  if (i_ready)    state_next = ST_IDLE;
            default:                  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) state <= ST_IDLE;
        else          state <= state_next;
    end

    // Single-cycle datapath; a shift only lands here when its amount is zero.
    always_comb begin
        sum          = i_a + i_b;
        diff         = i_a - i_b;
        alu_result   = '0;
        alu_overflow = 1'b0;
        alu_illegal  = 1'b0;
        case (i_alu_func)
            ALU_ADD: begin
                alu_result   = sum;
                alu_overflow = (i_a[WIDTH-1] == i_b[WIDTH-1]) && (sum[WIDTH-1] != i_a[WIDTH-1]);
            end
            ALU_SUB: begin
                alu_result   = diff;
                alu_overflow = (i_a[WIDTH-1] != i_b[WIDTH-1]) && (diff[WIDTH-1] != i_a[WIDTH-1]);
            end
            ALU_AND: alu_result = i_a & i_b;
            ALU_OR:  alu_result = i_a | i_b;
            ALU_NOR: alu_result = ~(i_a | i_b);
            ALU_XOR: alu_result = i_a ^ i_b;
            ALU_SLL, ALU_SRL, ALU_SRA: alu_result = i_b;
            default: alu_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_result   <= '0;
            o_zero     <= 1'b0;
            o_overflow <= 1'b0;
            o_illegal  <= 1'b0;
        end else if (accept && !start_shift) begin
            o_result   <= alu_result;
            o_zero     <= (alu_result == '0);
            o_overflow <= alu_overflow;
            o_illegal  <= alu_illegal;
        end else if (shift_done) begin
            o_result   <= shift_value;
            o_zero     <= (shift_value == '0);
            o_overflow <= 1'b0;
            o_illegal  <= 1'b0;
        end
    end

    alu_serial_shifter #(.WIDTH(WIDTH)) u_shifter (
        .clk      (i_clk),
        .rst_n    (i_rst_n),
        .load     (start_shift),
        .mode_in  (shift_mode_t'(i_alu_func[1:0])),
        .value_in (i_b),
        .count_in (i_shamt),
        .done     (shifter_done),
        .value    (shift_value)
    );

endmodule

// File: tb/tb_alu_seq_unit.sv
// Self-checking bench for alu_seq_unit: table-driven single requests plus
// hand-written reset, back-pressure and back-to-back sequences.
module tb_alu_seq_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [3:0]  i_alu_func;
    logic [31:0] i_a;
    logic [31:0] i_b;
    logic [4:0]  i_shamt;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_result;
    logic        o_zero;
    logic        o_overflow;
    logic        o_illegal;

    typedef struct {
        logic [3:0]  func;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  shamt;
        logic [31:0] res;
        logic        zero;
        logic        ovf;
        logic        ill;
        int          lat;
    } vec_t;

    typedef struct packed {
        logic [31:0] res;
        logic        zero;
        logic        ovf;
        logic        ill;
    } exp_t;

    localparam int NVEC = 16;
    vec_t vecs[NVEC];
    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    alu_seq_unit #(.WIDTH(32)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_alu_func (i_alu_func),
        .i_a        (i_a),
        .i_b        (i_b),
        .i_shamt    (i_shamt),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_result   (o_result),
        .o_zero     (o_zero),
        .o_overflow (o_overflow),
        .o_illegal  (o_illegal)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Drives one request from the current negedge; returns after the accept edge.
    task automatic applyStimulus(input vec_t v);
        checkOutput("ready_before_req", {31'd0, o_ready}, 32'd1);
        i_valid    = 1'b1;
        i_alu_func = v.func;
        i_a        = v.a;
        i_b        = v.b;
        i_shamt    = v.shamt;
        @(posedge clk);
        sb.push_back('{res: v.res, zero: v.zero, ovf: v.ovf, ill: v.ill});
        #1;
        i_valid    = 1'b0;
        i_alu_func = 4'($urandom);
        i_a        = $urandom;
        i_b        = $urandom;
        i_shamt    = 5'($urandom);
    endtask

    task automatic waitValid(output int lat);
        @(negedge clk);
        lat = 1;
        while (!o_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic popCompare(input string name);
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL %s_scoreboard actual=empty required=entry", name);
        end else begin
            e = sb.pop_front();
            checkOutput({name, "_res"},  o_result, e.res);
            checkOutput({name, "_zero"}, {31'd0, o_zero}, {31'd0, e.zero});
            checkOutput({name, "_ovf"},  {31'd0, o_overflow}, {31'd0, e.ovf});
            checkOutput({name, "_ill"},  {31'd0, o_illegal}, {31'd0, e.ill});
        end
    endtask

    task automatic handshake();
        i_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_ready = 1'b0;
        checkOutput("post_hs_valid", {31'd0, o_valid}, 32'd0);
        checkOutput("post_hs_ready", {31'd0, o_ready}, 32'd1);
    endtask

    initial begin
        int lat;
        int cnt;
        int got;
        int acc_cyc[4];
        string nm;

        vecs[0]  = '{4'b1000, 32'h7FFFFFFF, 32'h00000001, 5'd0,  32'h80000000, 1'b0, 1'b1, 1'b0, 1};
        vecs[1]  = '{4'b1001, 32'h00000005, 32'h00000005, 5'd0,  32'h00000000, 1'b1, 1'b0, 1'b0, 1};
        vecs[2]  = '{4'b1100, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  32'hF000F000, 1'b0, 1'b0, 1'b0, 1};
        vecs[3]  = '{4'b1101, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  32'hFFF0FFF0, 1'b0, 1'b0, 1'b0, 1};
        vecs[4]  = '{4'b1110, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  32'h000F000F, 1'b0, 1'b0, 1'b0, 1};
        vecs[5]  = '{4'b1111, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  32'h0FF00FF0, 1'b0, 1'b0, 1'b0, 1};
        vecs[6]  = '{4'b0010, 32'h12345678, 32'h80000000, 5'd31, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 32};
        vecs[7]  = '{4'b0001, 32'h12345678, 32'h80000000, 5'd31, 32'h00000001, 1'b0, 1'b0, 1'b0, 32};
        vecs[8]  = '{4'b0000, 32'hDEADBEEF, 32'h00000001, 5'd0,  32'h00000001, 1'b0, 1'b0, 1'b0, 1};
        vecs[9]  = '{4'b0111, 32'h0000FFFF, 32'h0000FFFF, 5'd3,  32'h00000000, 1'b1, 1'b0, 1'b1, 1};
        vecs[10] = '{4'b1001, 32'h80000000, 32'h00000001, 5'd0,  32'h7FFFFFFF, 1'b0, 1'b1, 1'b0, 1};
        vecs[11] = '{4'b0000, 32'h00000000, 32'h00000003, 5'd4,  32'h00000030, 1'b0, 1'b0, 1'b0, 5};
        vecs[12] = '{4'b0010, 32'h00000000, 32'h0F000000, 5'd3,  32'h01E00000, 1'b0, 1'b0, 1'b0, 4};
        vecs[13] = '{4'b0001, 32'hFFFFFFFF, 32'h00000000, 5'd2,  32'h00000000, 1'b1, 1'b0, 1'b0, 3};
        vecs[14] = '{4'b1000, 32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000000, 1'b1, 1'b0, 1'b0, 1};
        vecs[15] = '{4'b0010, 32'h00000000, 32'h80000000, 5'd0,  32'h80000000, 1'b0, 1'b0, 1'b0, 1};

        rst_n = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b0;
        i_alu_func = '0;
        i_a = '0;
        i_b = '0;
        i_shamt = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("rst_valid", {31'd0, o_valid}, 32'd0);
        checkOutput("rst_result", o_result, 32'd0);
        checkOutput("rst_zero", {31'd0, o_zero}, 32'd0);
        checkOutput("rst_ovf", {31'd0, o_overflow}, 32'd0);
        checkOutput("rst_ill", {31'd0, o_illegal}, 32'd0);
        checkOutput("rst_ready", {31'd0, o_ready}, 32'd1);

        for (int i = 0; i < NVEC; i++) begin
            nm = $sformatf("vec%0d", i);
            applyStimulus(vecs[i]);
            waitValid(lat);
            checkOutput({nm, "_lat"}, 32'(lat), 32'(vecs[i].lat));
            if (o_valid) popCompare(nm);
            else void'(sb.pop_front());
            handshake();
        end

        // Back-pressure: result must hold while the consumer stalls.
        applyStimulus(vecs[5]);
        waitValid(lat);
        checkOutput("bp_lat", 32'(lat), 32'd1);
        for (int c = 0; c < 5; c++) begin
            checkOutput("bp_valid", {31'd0, o_valid}, 32'd1);
            checkOutput("bp_result", o_result, 32'h0FF00FF0);
            checkOutput("bp_ready", {31'd0, o_ready}, 32'd0);
            if (c == 2) begin
                i_valid = 1'b1;
                i_alu_func = 4'b1000;
                i_a = 32'd1;
                i_b = 32'd2;
            end else begin
                i_valid = 1'b0;
            end
            @(negedge clk);
        end
        i_valid = 1'b0;
        popCompare("bp");
        handshake();
        cnt = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (o_valid) cnt++;
        end
        checkOutput("bp_ignored_req", 32'(cnt), 32'd0);

        // Reset mid-SHIFT: the in-flight shift must never be reported.
        applyStimulus('{4'b0001, 32'd0, 32'hFFFF0000, 5'd20, 32'h00000FFF, 1'b0, 1'b0, 1'b0, 21});
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        sb.delete();
        checkOutput("midrst_ready", {31'd0, o_ready}, 32'd1);
        checkOutput("midrst_valid", {31'd0, o_valid}, 32'd0);
        i_ready = 1'b1;
        cnt = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (o_valid) cnt++;
        end
        checkOutput("midrst_never_valid", 32'(cnt), 32'd0);

        // Back-to-back with i_ready tied high: one accept every two cycles.
        got = 0;
        fork
            begin
                for (int k = 0; k < 4; k++) begin
                    i_valid = 1'b1;
                    i_alu_func = vecs[2+k].func;
                    i_a = vecs[2+k].a;
                    i_b = vecs[2+k].b;
                    i_shamt = vecs[2+k].shamt;
                    cnt = 0;
                    while (!o_ready && cnt < 20) begin
                        @(negedge clk);
                        cnt++;
                    end
                    acc_cyc[k] = cyc;
                    @(posedge clk);
                    sb.push_back('{res: vecs[2+k].res, zero: vecs[2+k].zero,
                                   ovf: vecs[2+k].ovf, ill: vecs[2+k].ill});
                    @(negedge clk);
                end
                i_valid = 1'b0;
            end
            begin
                for (int g = 0; g < 40 && got < 4; g++) begin
                    @(negedge clk);
                    if (o_valid && i_ready) begin
                        popCompare($sformatf("b2b%0d", got));
                        got++;
                    end
                end
            end
        join
        checkOutput("b2b_count", 32'(got), 32'd4);
        for (int k = 1; k < 4; k++)
            checkOutput($sformatf("b2b_interval%0d", k), 32'(acc_cyc[k] - acc_cyc[k-1]), 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_seq_unit.md
# alu_seq_unit

Multi-cycle execute unit that consumes the 4-bit ALU function code produced by the ALU control decoder, together with operands, and returns a 32-bit result. Logic ops and add/sub complete in one cycle. Shifts run bit-serially, one position per cycle, to save area. Sits in the execute stage behind a valid/ready handshake on both sides, so the controller can stall on long shifts.

## Interface

- WIDTH, 32, datapath width. The shift-count width is derived as $clog2(WIDTH).
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst_n  input  1  reset, synchronous and active-low.
- i_valid  input  1  operation request valid.
- o_ready  output  1  unit can accept a request; equals (state == IDLE).
- i_alu_func  input  4  function code (see Operation).
- i_a  input  WIDTH  operand A (rs).
- i_b  input  WIDTH  operand B (rt or sign/zero-extended immediate); this is the shifted operand.
- i_shamt  input  $clog2(WIDTH)  shift amount.
- o_valid  output  1  result valid; held until accepted.
- i_ready  input  1  consumer accepts the result.
- o_result  output  WIDTH  result.
- o_zero  output  1  o_result == 0.
- o_overflow  output  1  signed overflow on ADD/SUB.
- o_illegal  output  1  the function code was not recognised.

## Operation

- A request is accepted on any cycle where i_valid && o_ready. i_alu_func, i_a, i_b and i_shamt are captured on that edge. Inputs are don't-care on all other cycles.
- Function codes:
  - 1000 ADD: a+b.
  - 1001 SUB: a-b.
  - 1100 AND.
  - 1101 OR.
  - 1110 NOR: ~(a|b).
  - 1111 XOR.
  - 0000 SLL: b<<shamt.
  - 0001 SRL: b>>shamt, zero fill.
  - 0010 SRA: b>>>shamt, sign fill.
  - Any other code: result 0, o_illegal=1, completes in one cycle.
- Arithmetic is modulo 2^WIDTH.
- o_overflow is set only for ADD/SUB:
  - ADD: operands have the same sign and the result sign differs.
  - SUB: operands have different signs and the result sign differs from a.
  - It is 0 for all other ops.
- FSM has three states: IDLE, SHIFT and DONE.
- IDLE, on accept:
  - Shift op with shamt != 0: load i_b into the shift register, load shamt into the down-counter, go to SHIFT.
  - Otherwise: compute the result, register it and the flags, go to DONE.
- SHIFT: each cycle, shift the register by one position in the captured direction and fill mode, then decrement the counter. On the cycle the counter reaches 1, the final shifted value is written to o_result and the state goes to DONE.
- DONE: o_valid=1, and o_result and the flags are stable. When i_ready is high, go to IDLE.
- Shift by 0 returns b unchanged, one cycle.
- Shift by WIDTH-1 takes WIDTH-1 SHIFT cycles. SRA of a negative value by WIDTH-1 yields all ones.
- Reset while in any state: the next state is IDLE; any in-flight operation is discarded and never reported.

## Timing

- Reset values: o_valid=0, o_result=0, o_zero=0, o_overflow=0, o_illegal=0, state=IDLE, so o_ready=1 on the first cycle after reset.
- Accept at edge N, non-shift or shamt=0: o_valid=1 from cycle N+1.
- Accept at edge N, shift with shamt=k>0: o_valid=1 from cycle N+1+k.
- o_valid and i_ready both high at edge M: o_valid=0 and o_ready=1 from cycle M+1.
  - No same-cycle turnaround: a new request cannot be accepted at edge M.
  - Minimum issue interval is 2 cycles.
- o_ready is 0 throughout SHIFT and DONE; i_valid is ignored there.
- o_zero and o_illegal are registered with o_result and are valid whenever o_valid is high.
- o_result holds its last value after hand-off until the next completion; it is only meaningful while o_valid is high.

## Structure

- Shared package alu_pkg:
  - Function-code localparams ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_NOR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA.
  - FSM state encoding.
  - The decoder migrates to the same function-code constants.
- One sub-module, alu_serial_shifter:
  - Contents: shift register, down-counter, direction and fill mode.
  - Interface: load/start in, done pulse out, value out.
- Single-cycle ops stay inline in alu_seq_unit.

## Test plan

- Reset held 2 cycles, then released -> all outputs 0, o_ready=1. Assert reset mid-SHIFT -> IDLE next cycle, o_valid never rises.
- ADD 0x7FFFFFFF + 0x00000001 -> o_valid at N+1, result 0x80000000, o_overflow=1, o_zero=0. SUB 5-5 -> result 0, o_zero=1, o_overflow=0.
- AND/OR/NOR/XOR with a=0xF0F0F0F0, b=0xFF00FF00 -> 0xF000F000, 0xFFF0FFF0, 0x000F000F, 0x0FF00FF0, each one cycle.
- SRA b=0x80000000, shamt=31 -> 0xFFFFFFFF at N+32. SRL same operands -> 0x00000001. SLL b=1, shamt=0 -> 1 at N+1.
- Back-pressure: hold i_ready=0 for 5 cycles in DONE -> o_valid and o_result stable, o_ready=0, a pulsed i_valid is ignored. Release -> o_ready=1 the next cycle.
- Illegal code 0111 -> result 0, o_illegal=1 at N+1. Back-to-back requests with i_ready tied high -> one accept every 2 cycles, results in order.
